cfg_write_arbiter: RTL and testbench

//  Owns the 8-bit configuration register bank behind the SPI slave write port and shares it between two

---
 rtl/cfg_pkg.sv | 25 ++
 rtl/cfg_wr_fifo.sv | 48 ++++
 rtl/cfg_write_arbiter.sv | 115 +++++++++++
 tb/tb_cfg_write_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration write path: register map, write record, grant owner.
package cfg_pkg;

    localparam int CFG_NUM_REGS   = 5;
    localparam int CFG_DW         = 8;
    localparam int CFG_AW         = 7;
    localparam int CFG_FIFO_DEPTH = 2;

    localparam logic [CFG_AW-1:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [CFG_AW-1:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [CFG_AW-1:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [CFG_AW-1:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [CFG_AW-1:0] ADDR_PWM_DUTY  = 7'd4;

    typedef struct packed {
        logic [CFG_AW-1:0] addr;
        logic [CFG_DW-1:0] data;
    } cfg_wr_t;

    typedef enum logic {
        GNT_SPI = 1'b0,
        GNT_SEQ = 1'b1
    } cfg_gnt_e;

endpackage

// File: rtl/cfg_wr_fifo.sv
// Small synchronous FIFO holding SPI writes until the arbiter grants them.
// Push while full is accepted only when a pop happens in the same cycle.
module cfg_wr_fifo
    import cfg_pkg::*;
#(
    parameter int DEPTH = CFG_FIFO_DEPTH
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  cfg_wr_t push_data,
    input  logic    pop,
    output cfg_wr_t head,
    output logic    full,
    output logic    empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // Extra pointer bit distinguishes full from empty when the indices match.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    cfg_wr_t       mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr[IW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[IW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cfg_write_arbiter.sv
// Configuration register bank shared by the SPI decoder (non-stalling, buffered) and the sequencer
// (valid/ready); writes go to a shadow bank and reach regs_out only on commit.
module cfg_write_arbiter
    import cfg_pkg::*;
#(
    parameter int NUM_REGS   = CFG_NUM_REGS,
    parameter int DW         = CFG_DW,
    parameter int AW         = CFG_AW,
    parameter int FIFO_DEPTH = CFG_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   spi_wr_valid,
    input  logic [AW-1:0]          spi_wr_addr,
    input  logic [DW-1:0]          spi_wr_data,
    input  logic                   seq_wr_valid,
    output logic                   seq_wr_ready,
    input  logic [AW-1:0]          seq_wr_addr,
    input  logic [DW-1:0]          seq_wr_data,
    input  logic                   commit_tick,
    input  logic                   immediate,
    input  logic                   err_clr,
    output logic [NUM_REGS*DW-1:0] regs_out,
    output logic [NUM_REGS-1:0]    pending,
    output logic                   err_overflow,
    output logic                   err_addr
);

    cfg_gnt_e      last_grant;
    cfg_wr_t       fifo_head;
    cfg_wr_t       wr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          seq_gnt;
    logic          spi_gnt;
    logic          wr_valid;
    logic          addr_ok;
    logic          do_commit;
    logic          overflow_set;
    logic          addr_err_set;
    logic [NUM_REGS-1:0] hit;
    logic [DW-1:0] shadow [NUM_REGS];
    logic [DW-1:0] active [NUM_REGS];

    // Sequencer handshake: a write transfers on any cycle where seq_wr_valid && seq_wr_ready; ready is a
    // function of arbiter state only, and the sequencer holds addr/data steady until the transfer.
    assign seq_wr_ready = fifo_empty || (last_grant == GNT_SPI);
    assign seq_gnt      = seq_wr_valid && seq_wr_ready;
    assign spi_gnt      = !seq_gnt && !fifo_empty;
    assign fifo_pop     = spi_gnt;
    assign fifo_push    = spi_wr_valid && (!fifo_full || fifo_pop);
    assign overflow_set = spi_wr_valid && fifo_full && !fifo_pop;

    cfg_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ('{addr: spi_wr_addr, data: spi_wr_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wr           = seq_gnt ? '{addr: seq_wr_addr, data: seq_wr_data} : fifo_head;
    assign wr_valid     = seq_gnt || spi_gnt;
    assign addr_ok      = (32'(wr.addr) < NUM_REGS);
    assign addr_err_set = wr_valid && !addr_ok;
    assign do_commit    = immediate || commit_tick;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hit[i] = wr_valid && addr_ok && (wr.addr == AW'(i));
        end
    end

    // Commit copies the pre-write shadow; only immediate mode lets the granted write pass straight through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            pending      <= '0;
            last_grant   <= GNT_SEQ;
            err_overflow <= 1'b0;
            err_addr     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (hit[i]) shadow[i] <= wr.data;
                if (immediate && hit[i]) active[i] <= wr.data;
                else if (do_commit && pending[i]) active[i] <= shadow[i];
                if (hit[i] && !immediate) pending[i] <= 1'b1;
                else if (do_commit) pending[i] <= 1'b0;
            end
            if (seq_gnt)      last_grant <= GNT_SEQ;
            else if (spi_gnt) last_grant <= GNT_SPI;
            if (overflow_set) err_overflow <= 1'b1;
            else if (err_clr) err_overflow <= 1'b0;
            if (addr_err_set) err_addr <= 1'b1;
            else if (err_clr) err_addr <= 1'b0;
        end
    end

    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_out[i*DW +: DW] = active[i];
        end
    end

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Directed bench for cfg_write_arbiter: shadow/commit timing, round-robin arbitration, errors, reset.
module tb_cfg_write_arbiter;
    import cfg_pkg::*;

    localparam int NR = 5;
    localparam int DW = 8;
    localparam int AW = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             spi_wr_valid;
    logic [AW-1:0]    spi_wr_addr;
    logic [DW-1:0]    spi_wr_data;
    logic             seq_wr_valid;
    logic             seq_wr_ready;
    logic [AW-1:0]    seq_wr_addr;
    logic [DW-1:0]    seq_wr_data;
    logic             commit_tick;
    logic             immediate;
    logic             err_clr;
    logic [NR*DW-1:0] regs_out;
    logic [NR-1:0]    pending;
    logic             err_overflow;
    logic             err_addr;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    // Per-cycle expectations for the contention run (SPI pulse every cycle for k=0..4, sequencer to reg0).
    // The FIFO nets one entry per two cycles, so with depth 2 the fifth pulse is the first dropped.
    logic          exp_rdy [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [DW-1:0] exp_r0  [7] = '{8'h40, 8'h40, 8'h41, 8'h41, 8'h42, 8'h42, 8'h42};
    logic          exp_ovf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    cfg_write_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_wr_valid (spi_wr_valid),
        .spi_wr_addr  (spi_wr_addr),
        .spi_wr_data  (spi_wr_data),
        .seq_wr_valid (seq_wr_valid),
        .seq_wr_ready (seq_wr_ready),
        .seq_wr_addr  (seq_wr_addr),
        .seq_wr_data  (seq_wr_data),
        .commit_tick  (commit_tick),
        .immediate    (immediate),
        .err_clr      (err_clr),
        .regs_out     (regs_out),
        .pending      (pending),
        .err_overflow (err_overflow),
        .err_addr     (err_addr)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] reg_val(input int i);
        return regs_out[i*DW +: DW];
    endfunction

    // Driver tasks: inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_spi(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        spi_wr_valid = v;
        spi_wr_addr  = a;
        spi_wr_data  = d;
    endtask

    task automatic set_seq(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        seq_wr_valid = v;
        seq_wr_addr  = a;
        seq_wr_data  = d;
    endtask

    task automatic idle();
        set_spi(1'b0, '0, '0);
        set_seq(1'b0, '0, '0);
        commit_tick = 1'b0;
        err_clr     = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] seq_d;
        logic [DW-1:0] last_r1;

        rst_n     = 1'b0;
        immediate = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_regs", regs_out, '0);
        check("reset_pending", pending, '0);
        check("reset_err_ovf", err_overflow, 1'b0);
        check("reset_err_addr", err_addr, 1'b0);
        check("reset_ready", seq_wr_ready, 1'b1);

        // 1: SPI write stays in shadow until commit_tick.
        set_spi(1'b1, 7'd2, 8'hA5);
        cycle();
        set_spi(1'b0, '0, '0);
        check("t1_pend_after_push", pending, 5'b00000);
        cycle();
        check("t1_pending", pending, 5'b00100);
        check("t1_regs_held", regs_out, '0);
        commit_tick = 1'b1;
        cycle();
        commit_tick = 1'b0;
        check("t1_reg2", reg_val(2), 8'hA5);
        check("t1_pend_clr", pending, 5'b00000);

        // 3: out-of-range address, error clear, and set-beats-clear.
        set_spi(1'b1, 7'd7, 8'h11);
        cycle();
        set_spi(1'b0, '0, '0);
        cycle();
        check("t3_err_addr", err_addr, 1'b1);
        check("t3_regs", regs_out, 40'h00_00_A5_00_00);
        check("t3_pending", pending, 5'b00000);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check("t3_err_clr", err_addr, 1'b0);
        set_spi(1'b1, 7'd9, 8'h22);
        cycle();
        set_spi(1'b0, '0, '0);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check("t3_set_wins", err_addr, 1'b1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;

        // 2: contention in immediate mode, grants visible on reg0 (SEQ) and reg1 (SPI).
        immediate = 1'b1;
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h14};
        seq_d   = 8'h40;
        last_r1 = reg_val(1);
        for (int k = 0; k < 7; k++) begin
            logic accepted;
            if (k < 5) begin
                set_spi(1'b1, 7'd1, 8'(8'h11 + k));
                set_seq(1'b1, 7'd0, seq_d);
            end else begin
                set_spi(1'b0, '0, '0);
                set_seq(1'b0, '0, '0);
            end
            check($sformatf("t2_ready_%0d", k), seq_wr_ready, exp_rdy[k]);
            accepted = seq_wr_valid && seq_wr_ready;
            cycle();
            if (accepted) seq_d = seq_d + 8'h01;
            check($sformatf("t2_reg0_%0d", k), reg_val(0), exp_r0[k]);
            check($sformatf("t2_ovf_%0d", k), err_overflow, exp_ovf[k]);
            if (reg_val(1) != last_r1) begin
                if (exp_q.size() > 0) check("t2_spi_order", reg_val(1), exp_q.pop_front());
                else check("t2_spi_extra", reg_val(1), last_r1);
                last_r1 = reg_val(1);
            end
        end
        idle();
        check("t2_drained", exp_q.size(), 0);
        check("t2_ready_empty", seq_wr_ready, 1'b1);
        check("t2_pending", pending, 5'b00000);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check("t2_ovf_clr", err_overflow, 1'b0);

        // 4: immediate write-through, visible two cycles after the pulse.
        set_spi(1'b1, 7'd4, 8'h80);
        cycle();
        set_spi(1'b0, '0, '0);
        check("t4_reg4_n1", reg_val(4), 8'h00);
        cycle();
        check("t4_reg4_n2", reg_val(4), 8'h80);
        check("t4_pending", pending, 5'b00000);
        immediate = 1'b0;

        // 5: commit in the grant cycle takes the old shadow value.
        set_seq(1'b1, 7'd3, 8'h01);
        check("t5_ready", seq_wr_ready, 1'b1);
        cycle();
        set_seq(1'b0, '0, '0);
        check("t5_pend_first", pending, 5'b01000);
        set_seq(1'b1, 7'd3, 8'h02);
        commit_tick = 1'b1;
        cycle();
        set_seq(1'b0, '0, '0);
        commit_tick = 1'b0;
        check("t5_reg3_old", reg_val(3), 8'h01);
        check("t5_pend_kept", pending, 5'b01000);
        commit_tick = 1'b1;
        cycle();
        commit_tick = 1'b0;
        check("t5_reg3_new", reg_val(3), 8'h02);
        check("t5_pend_clr", pending, 5'b00000);

        // Switching immediate on flushes whatever is pending.
        set_seq(1'b1, 7'd0, 8'h77);
        cycle();
        set_seq(1'b0, '0, '0);
        check("t5b_pending", pending, 5'b00001);
        check("t5b_reg0_held", reg_val(0), 8'h42);
        immediate = 1'b1;
        cycle();
        immediate = 1'b0;
        check("t5b_reg0_flush", reg_val(0), 8'h77);
        check("t5b_pend_clr", pending, 5'b00000);

        // 6: reset with every register pending and two SPI entries queued.
        for (int i = 0; i < 4; i++) begin
            set_seq(1'b1, AW'(i), 8'(8'h50 + i));
            cycle();
        end
        set_seq(1'b1, 7'd4, 8'h54);
        set_spi(1'b1, 7'd0, 8'hE1);
        cycle();
        set_seq(1'b1, 7'd2, 8'h62);
        set_spi(1'b1, 7'd0, 8'hE2);
        cycle();
        set_spi(1'b1, 7'd0, 8'hE3);
        cycle();
        idle();
        check("t6_pend_all", pending, 5'b11111);
        check("t6_fifo_busy", seq_wr_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_regs", regs_out, '0);
        check("t6_rst_pending", pending, '0);
        check("t6_rst_ovf", err_overflow, 1'b0);
        check("t6_rst_err_addr", err_addr, 1'b0);
        check("t6_rst_ready", seq_wr_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        commit_tick = 1'b1;
        cycle();
        commit_tick = 1'b0;
        repeat (3) cycle();
        commit_tick = 1'b1;
        cycle();
        commit_tick = 1'b0;
        check("t6_post_regs", regs_out, '0);
        check("t6_post_pending", pending, '0);
        check("t6_post_ready", seq_wr_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
